// File: rtl/int_pend_pkg.sv
// int_pend_pkg: shared FSM state encoding and parameter defaults for the interrupt pending controller
package int_pend_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ASSERTED, S_HOLDOFF} state_t;
  localparam int DEF_NUM_SRC = 3;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_HOLDOFF = 4;
endpackage

// File: rtl/int_pend_ctrl_if.sv
// int_pend_ctrl_if: software/source-side request, control and status bundle of the interrupt pending controller
interface int_pend_ctrl_if
  import int_pend_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int CNT_W   = DEF_CNT_W
);
  logic [NUM_SRC-1:0]       src_i;
  logic [NUM_SRC-1:0]       en_i;
  logic [NUM_SRC-1:0]       route_i;
  logic [NUM_SRC-1:0]       clr_i;
  logic [NUM_SRC-1:0]       cnt_clr_i;
  logic [3:0]               fiq_o;
  logic [3:0]               irq_o;
  logic [NUM_SRC-1:0]       pend_o;
  logic [NUM_SRC-1:0]       ovr_o;
  logic [NUM_SRC*CNT_W-1:0] cnt_o;
  modport master (
    output src_i, en_i, route_i, clr_i, cnt_clr_i,
    input  fiq_o, irq_o, pend_o, ovr_o, cnt_o
  );
  modport slave (
    input  src_i, en_i, route_i, clr_i, cnt_clr_i,
    output fiq_o, irq_o, pend_o, ovr_o, cnt_o
  );
endinterface

// File: rtl/int_src_fsm.sv
// int_src_fsm: per-source edge capture (armed one clock after reset so a level already high is not an event), pending FSM with holdoff, saturating event counter and sticky overrun
module int_src_fsm
  import int_pend_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic             clk100,
  input  logic             rstn,
  input  logic             src_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             cnt_clr_i,
  output logic             pend_o,
  output logic             ovr_o,
  output logic [CNT_W-1:0] cnt_o
);
  localparam int HW = $clog2(HOLDOFF + 1);
  state_t           state_q, state_d;
  logic             src_q, arm_q, lp_q, lp_d, ovr_q, ovr_d, pend_q, pend_d, ev;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    ev      = src_i & ~src_q & arm_q & en_i;
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lp_d    = lp_q;
    case (state_q)
      S_IDLE:     state_d = ev ? S_ASSERTED : S_IDLE;
      S_ASSERTED: if (clr_i) begin
        state_d = S_HOLDOFF;
        hcnt_d  = HW'(HOLDOFF - 1);
        lp_d    = ev;
      end
      S_HOLDOFF:  if (hcnt_q == '0) begin
        state_d = (lp_q | ev) ? S_ASSERTED : S_IDLE;
        lp_d    = 1'b0;
      end else begin
        hcnt_d  = hcnt_q - 1'b1;
        lp_d    = lp_q | ev;
      end
      default:    state_d = S_IDLE;
    endcase
    ovr_d  = cnt_clr_i ? 1'b0 : ovr_q | (state_q == S_ASSERTED && ev && !clr_i);
    cnt_d  = cnt_clr_i ? CNT_W'(ev) : (ev && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    pend_d = state_q == S_ASSERTED && en_i;
  end
  always_ff @(posedge clk100 or negedge rstn)
    if (!rstn) begin
      state_q <= S_IDLE;
      src_q   <= 1'b0;
      arm_q   <= 1'b0;
      lp_q    <= 1'b0;
      hcnt_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_i;
      arm_q   <= 1'b1;
      lp_q    <= lp_d;
      hcnt_q  <= hcnt_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      pend_q  <= pend_d;
    end
  assign pend_o = pend_q;
  assign ovr_o  = ovr_q;
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/int_pend_ctrl.sv
// int_pend_ctrl: per-source pending FSMs merged into registered GIC FIQ/IRQ lines by software routing
module int_pend_ctrl
  import int_pend_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input logic             clk100,
  input logic             rstn,
  int_pend_ctrl_if.slave  bus
);
  logic [NUM_SRC-1:0]       pend, ovr;
  logic [NUM_SRC*CNT_W-1:0] cnt;
  logic                     fiq_q, fiq_d, irq_q, irq_d;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    int_src_fsm #(.CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) u_src (
      .clk100    (clk100),
      .rstn      (rstn),
      .src_i     (bus.src_i[i]),
      .en_i      (bus.en_i[i]),
      .clr_i     (bus.clr_i[i]),
      .cnt_clr_i (bus.cnt_clr_i[i]),
      .pend_o    (pend[i]),
      .ovr_o     (ovr[i]),
      .cnt_o     (cnt[i*CNT_W +: CNT_W])
    );
  end
  always_comb begin
    fiq_d = |(pend & bus.route_i);
    irq_d = |(pend & ~bus.route_i);
  end
  always_ff @(posedge clk100 or negedge rstn)
    if (!rstn) begin
      fiq_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      fiq_q <= fiq_d;
      irq_q <= irq_d;
    end
  assign bus.fiq_o  = {3'b000, fiq_q};
  assign bus.irq_o  = {3'b000, irq_q};
  assign bus.pend_o = pend;
  assign bus.ovr_o  = ovr;
  assign bus.cnt_o  = cnt;
endmodule

// File: tb/tb_int_pend_ctrl.sv
// tb_int_pend_ctrl: directed scenarios; expectations queued with their due cycle and checked by a negedge monitor
module tb_int_pend_ctrl;
  localparam int NS = 3;
  localparam int CW = 4;
  localparam int HO = 4;
  localparam int FIQ = 0, IRQ = 1, PEND = 2, OVR = 3, CNT = 4;
  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;
  logic  clk100 = 1'b0;
  logic  rstn   = 1'b0;
  int    cyc    = 0;
  int    total  = 0;
  int    bad    = 0;
  exp_t  q[$];
  int_pend_ctrl_if #(.NUM_SRC(NS), .CNT_W(CW)) bus();
  int_pend_ctrl #(.NUM_SRC(NS), .CNT_W(CW), .HOLDOFF(HO)) dut (
    .clk100 (clk100),
    .rstn   (rstn),
    .bus    (bus)
  );
  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;
  function automatic logic [31:0] obs(int sel);
    case (sel)
      FIQ:     return 32'(bus.fiq_o);
      IRQ:     return 32'(bus.irq_o);
      PEND:    return 32'(bus.pend_o);
      OVR:     return 32'(bus.ovr_o);
      default: return 32'(bus.cnt_o);
    endcase
  endfunction
  always @(negedge clk100) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        logic [31:0] got;
        got = obs(q[i].sel);
        total++;
        if (q[i].cyc < cyc || got !== q[i].val) begin
          bad++;
          $display("FAIL %s at cycle %0d: got %0h expected %0h", q[i].name, cyc, got, q[i].val);
        end
        q.delete(i);
      end
    end
  end
  task automatic tick();
    @(posedge clk100);
    #1;
  endtask
  task automatic chk(int off, int sel, logic [31:0] val, string name);
    q.push_back('{cyc + off, sel, val, name});
  endtask
  task automatic drain();
    for (int i = 0; i < 64 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked", q.size());
      $fatal(1, "scoreboard stuck");
    end
  endtask
  task automatic do_reset();
    rstn          = 1'b0;
    bus.src_i     = '0;
    bus.clr_i     = '0;
    bus.cnt_clr_i = '0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask
  initial begin
    bus.en_i    = 3'b111;
    bus.route_i = 3'b001;
    do_reset();
    chk(0, FIQ, 0, "rst_fiq");
    chk(0, IRQ, 0, "rst_irq");
    chk(0, PEND, 0, "rst_pend");
    chk(0, OVR, 0, "rst_ovr");
    chk(0, CNT, 0, "rst_cnt");
    tick();
    // single pulse on FIQ-routed source 0
    bus.src_i[0] = 1'b1;
    chk(1, CNT, 32'h001, "s0_cnt_early");
    chk(2, FIQ, 0, "s0_fiq_lat1");
    chk(2, PEND, 3'b001, "s0_pend");
    chk(3, FIQ, 1, "s0_fiq_lat2");
    chk(3, IRQ, 0, "s0_irq");
    chk(3, CNT, 32'h001, "s0_cnt");
    tick();
    bus.src_i[0] = 1'b0;
    drain();
    do_reset();
    // IRQ-routed source 1, software clear and holdoff
    bus.src_i[1] = 1'b1;
    tick();
    bus.src_i[1] = 1'b0;
    tick();
    tick();
    bus.clr_i[1] = 1'b1;
    chk(0, IRQ, 1, "clr_irq_before");
    chk(2, IRQ, 1, "clr_irq_lat1");
    chk(2, PEND, 0, "clr_pend");
    for (int k = 3; k <= 8; k++) chk(k, IRQ, 0, "clr_irq_low");
    tick();
    bus.clr_i[1] = 1'b0;
    drain();
    do_reset();
    // edge coincident with clear re-asserts after holdoff
    bus.src_i[1] = 1'b1;
    tick();
    bus.src_i[1] = 1'b0;
    repeat (3) tick();
    bus.src_i[1] = 1'b1;
    bus.clr_i[1] = 1'b1;
    chk(2, IRQ, 1, "coin_irq_still");
    chk(3, IRQ, 0, "coin_irq_low0");
    chk(6, IRQ, 0, "coin_irq_low3");
    chk(7, IRQ, 1, "coin_irq_back");
    chk(7, OVR, 0, "coin_ovr");
    chk(7, CNT, 32'h020, "coin_cnt");
    tick();
    bus.src_i[1] = 1'b0;
    bus.clr_i[1] = 1'b0;
    drain();
    do_reset();
    // second edge on source 2 while still asserted
    bus.src_i[2] = 1'b1;
    chk(3, IRQ, 1, "ovr_irq");
    chk(10, OVR, 0, "ovr_before");
    tick();
    bus.src_i[2] = 1'b0;
    repeat (9) tick();
    bus.src_i[2] = 1'b1;
    chk(1, OVR, 3'b100, "ovr_set");
    chk(1, CNT, 32'h200, "ovr_cnt");
    tick();
    bus.src_i[2] = 1'b0;
    drain();
    do_reset();
    // counter saturation then clear with a coincident edge
    for (int k = 0; k < 20; k++) begin
      bus.src_i[0] = 1'b1;
      tick();
      bus.src_i[0] = 1'b0;
      tick();
    end
    chk(0, CNT, 32'h00f, "sat_cnt");
    chk(0, OVR, 3'b001, "sat_ovr");
    bus.src_i[0]     = 1'b1;
    bus.cnt_clr_i[0] = 1'b1;
    chk(1, CNT, 32'h001, "cclr_cnt");
    chk(1, OVR, 0, "cclr_ovr");
    tick();
    bus.src_i[0]     = 1'b0;
    bus.cnt_clr_i[0] = 1'b0;
    drain();
    do_reset();
    // asynchronous reset during holdoff with the request held high
    bus.src_i[0] = 1'b1;
    repeat (3) tick();
    chk(0, FIQ, 1, "ar_fiq_up");
    bus.clr_i[0] = 1'b1;
    tick();
    bus.clr_i[0] = 1'b0;
    rstn = 1'b0;
    chk(0, FIQ, 0, "ar_fiq_async");
    chk(0, PEND, 0, "ar_pend_async");
    tick();
    rstn = 1'b1;
    chk(4, FIQ, 0, "ar_no_event");
    chk(4, CNT, 0, "ar_cnt_zero");
    repeat (4) tick();
    bus.src_i[0] = 1'b0;
    tick();
    bus.src_i[0] = 1'b1;
    chk(2, FIQ, 0, "ar_toggle_lat1");
    chk(3, FIQ, 1, "ar_toggle_fiq");
    chk(3, CNT, 32'h001, "ar_toggle_cnt");
    tick();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
